// File: rtl/sm_imem_loader_if.sv
// Byte-stream loader handshake for sm_imem_loader.
//   ld_valid : ld_byte carries a byte this cycle (master -> slave)
//   ld_byte  : stream byte                       (master -> slave)
//   ld_ready : slave accepts a byte              (slave -> master)
// A byte transfers on ld_valid & ld_ready at the rising clock edge.
interface sm_imem_loader_if;
    logic       ld_valid;
    logic       ld_ready;
    logic [7:0] ld_byte;

    modport master (output ld_valid, output ld_byte, input ld_ready);
    modport slave  (input ld_valid, input ld_byte, output ld_ready);
endinterface

// File: rtl/sm_imem_loader.sv
// Instruction memory for sm_cpu with a framed byte-stream boot loader.
// The CPU reads imData combinationally from imAddr; the loader writes a
// frame (A5, LEN_HI, LEN_LO, N*4 big-endian data bytes, XOR checksum) into
// memory and releases the CPU only once a frame with a good checksum lands.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   imAddr     : CPU word address, low ADDR_WIDTH bits used (aliases)
//   imData     : mem[imAddr], combinational
//   ld         : loader stream interface (slave side)
//   cpu_rst_n  : active-low CPU reset, high only in RUN
//   ld_done    : image loaded with good checksum (RUN)
//   ld_error   : last image rejected (ERROR)
module sm_imem_loader #(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        imAddr,
    output logic [31:0]        imData,
    sm_imem_loader_if.slave    ld,
    output logic               cpu_rst_n,
    output logic               ld_done,
    output logic               ld_error
);
    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);
    localparam logic [7:0]  SYNC_B  = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERROR
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [1:0]            idx;
    logic [7:0]            csum;
    logic [7:0]            len_hi;
    logic [15:0]           len;
    logic [23:0]           word;     // first three bytes of the word in flight
    logic [31:0]           mem [DEPTH];

    logic                  xfer;
    logic [15:0]           n_len;
    logic                  last_word;
    logic                  word_done;
    logic                  unused_addr;

    assign ld.ld_ready  = !rst;
    assign xfer         = ld.ld_valid & ld.ld_ready;
    assign n_len        = {len_hi, ld.ld_byte};
    assign last_word    = (16'(ptr) == len - 16'd1);
    assign word_done    = xfer && (state == S_DATA) && (idx == 2'd3);

    assign imData       = mem[imAddr[ADDR_WIDTH-1:0]];
    assign unused_addr  = ^imAddr[31:ADDR_WIDTH];

    assign cpu_rst_n    = (state == S_RUN);
    assign ld_done      = (state == S_RUN);
    assign ld_error     = (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (rst) state <= S_SYNC;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (xfer) begin
            case (state)
                S_SYNC:   if (ld.ld_byte == SYNC_B) state_nx = S_LEN_HI;
                S_LEN_HI: state_nx = S_LEN_LO;
                S_LEN_LO: begin
                    if ({1'b0, n_len} > DEPTH_W) state_nx = S_ERROR;
                    else if (n_len == 16'd0)     state_nx = S_CSUM;
                    else                         state_nx = S_DATA;
                end
                S_DATA:   if (idx == 2'd3 && last_word) state_nx = S_CSUM;
                S_CSUM:   state_nx = (ld.ld_byte == csum) ? S_RUN : S_ERROR;
                S_RUN,
                S_ERROR:  if (ld.ld_byte == SYNC_B) state_nx = S_LEN_HI;
                default:  state_nx = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            idx    <= '0;
            csum   <= '0;
            len_hi <= '0;
            len    <= '0;
            word   <= '0;
        end else if (xfer) begin
            case (state)
                S_LEN_HI: len_hi <= ld.ld_byte;
                S_LEN_LO: begin
                    // clearing csum here also yields the 0x00 expected for N = 0
                    len  <= n_len;
                    ptr  <= '0;
                    idx  <= '0;
                    csum <= '0;
                    word <= '0;
                end
                S_DATA: begin
                    word <= {word[15:0], ld.ld_byte};
                    csum <= csum ^ ld.ld_byte;
                    idx  <= idx + 2'd1;
                    // ptr holds at N-1 after the final word so it never wraps
                    if (idx == 2'd3 && !last_word) ptr <= ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset: contents survive rst and rejected frames.
    always_ff @(posedge clk) begin
        if (word_done) mem[ptr] <= {word, ld.ld_byte};
    end
endmodule
